// File: rtl/ram_bus_responder.sv
// Load/store responder between the MEM pipeline stage and a simple request/ack bus.
// Handles lane steering, load extension, misalignment/conflict errors and bus timeouts.
module ram_bus_responder #(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r_mem_enable_i,
   input  logic [31:0] r_mem_addr_i,
   input  logic        w_mem_enable_i,
   input  logic [31:0] w_mem_addr_i,
   input  logic [31:0] w_mem_data_i,
   input  logic [2:0]  data_type_i,
   output logic [31:0] r_mem_data_o,
   output logic        r_data_valid_o,
   output logic        hold_req_o,
   output logic        mem_err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      BUSY = 3'b010,
      RESP = 3'b100
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [2:0]  type_q;
   logic        we_q;
   logic        err_q;
   logic [7:0]  tmo_cnt;

   logic        start;
   logic        ack_hit;
   logic        tmo_hit;
   logic        req_any;
   logic        req_we;
   logic        conflict;
   logic        misaligned;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;

   function automatic logic [31:0] extract(input logic [31:0] data,
                                           input logic [1:0]  off,
                                           input logic [2:0]  dtype);
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      byte_sel = data[{off, 3'b000} +: 8];
      half_sel = off[1] ? data[31:16] : data[15:0];
      case (dtype)
         3'd1:    extract = {{24{byte_sel[7]}}, byte_sel};
         3'd2:    extract = {{16{half_sel[15]}}, half_sel};
         3'd4:    extract = {24'b0, byte_sel};
         3'd5:    extract = {16'b0, half_sel};
         default: extract = data;
      endcase
   endfunction

   // When both enables are up the store wins; the conflict only raises the error flag.
   always_comb begin
      req_any    = r_mem_enable_i | w_mem_enable_i;
      req_we     = w_mem_enable_i;
      req_addr   = w_mem_enable_i ? w_mem_addr_i : r_mem_addr_i;
      conflict   = r_mem_enable_i & w_mem_enable_i;
      is_byte    = (data_type_i == 3'd1) || (data_type_i == 3'd4);
      is_half    = (data_type_i == 3'd2) || (data_type_i == 3'd5);
      is_word    = (data_type_i == 3'd3) || (data_type_i == 3'd6) || (data_type_i == 3'd7);
      misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
      req_be     = 4'b1111;
      req_wdata  = '0;
      if (req_we) begin
         req_wdata = w_mem_data_i;
         if (is_byte) begin
            req_be    = 4'b0001 << req_addr[1:0];
            req_wdata = {4{w_mem_data_i[7:0]}};
         end else if (is_half) begin
            req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{w_mem_data_i[15:0]}};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      ack_hit   = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (req_any) begin
               start     = 1'b1;
               state_nxt = misaligned ? RESP : BUSY;
            end
         end
         BUSY: begin
            if (bus_ack_i) begin
               ack_hit   = 1'b1;
               state_nxt = RESP;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Load results are extended as they are captured, so r_mem_data_o is stable through RESP and after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         type_q       <= '0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         tmo_cnt      <= '0;
         r_mem_data_o <= '0;
      end else begin
         if (start) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            type_q  <= data_type_i;
            we_q    <= req_we;
            err_q   <= misaligned | conflict;
            tmo_cnt <= '0;
            if (misaligned && !req_we) begin
               r_mem_data_o <= '0;
            end
         end else if (ack_hit) begin
            if (!we_q) begin
               r_mem_data_o <= extract(bus_rdata_i, addr_q[1:0], type_q);
            end
         end else if (tmo_hit) begin
            err_q <= 1'b1;
            if (!we_q) begin
               r_mem_data_o <= '0;
            end
         end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
      end
   end

   // hold_req_o is gated by rst_n so that reset forces it low even while enables are still asserted.
   always_comb begin
      bus_req_o      = (state == BUSY);
      bus_we_o       = we_q;
      bus_addr_o     = {addr_q[31:2], 2'b00};
      bus_wdata_o    = wdata_q;
      bus_be_o       = be_q;
      r_data_valid_o = (state == RESP) && !we_q;
      mem_err_o      = (state == RESP) && err_q;
      hold_req_o     = rst_n && (((state == IDLE) && req_any) || (state == BUSY));
   end

endmodule

// File: tb/tb_ram_bus_responder.sv
// Self-checking bench for ram_bus_responder: directed vector table, reset corner cases,
// and randomized accesses checked against a transaction-level reference model.
module tb_ram_bus_responder;

   localparam int TIMEOUT = 4;

   logic        clk;
   logic        rst_n;
   logic        r_mem_enable;
   logic [31:0] r_mem_addr;
   logic        w_mem_enable;
   logic [31:0] w_mem_addr;
   logic [31:0] w_mem_data;
   logic [2:0]  data_type;
   logic [31:0] r_mem_data;
   logic        r_data_valid;
   logic        hold_req;
   logic        mem_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int          n_checks;
   int          n_fail;
   string       tag;
   logic [31:0] last_data;

   typedef struct {
      logic        r_en;
      logic        w_en;
      logic [31:0] raddr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [2:0]  dtype;
      int          delay;
      logic [31:0] rdata;
      int          cycles;
      logic        exp_err;
      logic        exp_valid;
      logic        exp_we;
      logic [31:0] exp_data;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vectors[$];

   ram_bus_responder #(.BUS_TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .r_mem_enable_i (r_mem_enable),
      .r_mem_addr_i   (r_mem_addr),
      .w_mem_enable_i (w_mem_enable),
      .w_mem_addr_i   (w_mem_addr),
      .w_mem_data_i   (w_mem_data),
      .data_type_i    (data_type),
      .r_mem_data_o   (r_mem_data),
      .r_data_valid_o (r_data_valid),
      .hold_req_o     (hold_req),
      .mem_err_o      (mem_err),
      .bus_req_o      (bus_req),
      .bus_we_o       (bus_we),
      .bus_addr_o     (bus_addr),
      .bus_wdata_o    (bus_wdata),
      .bus_be_o       (bus_be),
      .bus_ack_i      (bus_ack),
      .bus_rdata_i    (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s %s: got 0x%08h expected 0x%08h", tag, what, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic w, input logic [31:0] raddr,
                               input logic [31:0] waddr, input logic [31:0] wdata,
                               input logic [2:0] dtype, input int delay, input logic [31:0] rdata,
                               input int cycles, input logic err, input logic valid,
                               input logic [31:0] data, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wd);
      vec_t v;
      v.r_en = r;         v.w_en = w;          v.raddr = raddr;   v.waddr = waddr;
      v.wdata = wdata;    v.dtype = dtype;     v.delay = delay;   v.rdata = rdata;
      v.cycles = cycles;  v.exp_err = err;     v.exp_valid = valid;
      v.exp_we = w;       v.exp_data = data;   v.exp_addr = addr;
      v.exp_be = be;      v.exp_wdata = wd;
      return v;
   endfunction

   // Reference model: outcome of one access derived from access size, offset and ack latency.
   function automatic vec_t model(input logic r, input logic w, input logic [31:0] raddr,
                                  input logic [31:0] waddr, input logic [31:0] wdata,
                                  input logic [2:0] dtype, input int delay, input logic [31:0] rdata);
      vec_t        v;
      int          size;
      int          off;
      bit          sgn;
      logic [31:0] addr;
      int unsigned val;
      v = mk(r, w, raddr, waddr, wdata, dtype, delay, rdata, 0, 0, 0, 0, 0, 4'hF, 0);
      addr = w ? waddr : raddr;
      case (dtype)
         3'd1, 3'd4: size = 1;
         3'd2, 3'd5: size = 2;
         default:    size = 4;
      endcase
      sgn = (dtype == 3'd1) || (dtype == 3'd2);
      off = int'(addr % 4);
      v.exp_addr  = addr - 32'(off);
      v.exp_valid = !w;
      if ((addr % size) != 0) begin
         v.cycles  = 0;
         v.exp_err = 1'b1;
      end else if (delay >= TIMEOUT) begin
         v.cycles  = TIMEOUT;
         v.exp_err = 1'b1;
      end else begin
         v.cycles  = delay + 1;
         v.exp_err = r && w;
      end
      if (!w && !v.exp_err) begin
         if (size == 4) begin
            v.exp_data = rdata;
         end else begin
            val = (rdata >> (8 * off)) % (1 << (8 * size));
            if (sgn && val >= (1 << (8 * size - 1)))
               v.exp_data = 32'(val) - 32'(1 << (8 * size));
            else
               v.exp_data = 32'(val);
         end
      end
      if (w) begin
         if (size == 1) begin
            v.exp_be    = 4'(1 << off);
            v.exp_wdata = 32'(wdata % 256) * 32'h01010101;
         end else if (size == 2) begin
            v.exp_be    = (off >= 2) ? 4'hC : 4'h3;
            v.exp_wdata = 32'(wdata % 65536) * 32'h00010001;
         end else begin
            v.exp_wdata = wdata;
         end
      end
      return v;
   endfunction

   // Runs one access from IDLE; inputs stay held through BUSY and RESP like a stalled pipeline register.
   task automatic apply_stimulus(input vec_t v);
      r_mem_enable = v.r_en;
      w_mem_enable = v.w_en;
      r_mem_addr   = v.raddr;
      w_mem_addr   = v.waddr;
      w_mem_data   = v.wdata;
      data_type    = v.dtype;
      #1;
      check_output("hold_idle", hold_req, 1);
      check_output("bus_req_idle", bus_req, 0);
      @(posedge clk); #1;
      for (int k = 0; k < v.cycles; k++) begin
         check_output($sformatf("bus_req_busy%0d", k), bus_req, 1);
         check_output($sformatf("hold_busy%0d", k), hold_req, 1);
         check_output("bus_we", bus_we, v.exp_we);
         check_output("bus_addr", bus_addr, v.exp_addr);
         check_output("bus_be", bus_be, v.exp_be);
         if (v.exp_we) check_output("bus_wdata", bus_wdata, v.exp_wdata);
         if (k == v.delay) begin
            bus_ack   = 1'b1;
            bus_rdata = v.rdata;
         end
         @(posedge clk); #1;
         bus_ack   = 1'b0;
         bus_rdata = $urandom;
      end
      check_output("bus_req_resp", bus_req, 0);
      check_output("hold_resp", hold_req, 0);
      check_output("valid_resp", r_data_valid, v.exp_valid);
      check_output("err_resp", mem_err, v.exp_err);
      if (v.exp_valid) last_data = v.exp_data;
      check_output("data_resp", r_mem_data, last_data);
      r_mem_enable = 1'b0;
      w_mem_enable = 1'b0;
      @(posedge clk); #1;
      check_output("valid_after", r_data_valid, 0);
      check_output("err_after", mem_err, 0);
      check_output("hold_after", hold_req, 0);
      check_output("data_hold", r_mem_data, last_data);
   endtask

   task automatic check_all_zero();
      check_output("r_mem_data", r_mem_data, 0);
      check_output("valid", r_data_valid, 0);
      check_output("hold", hold_req, 0);
      check_output("err", mem_err, 0);
      check_output("bus_req", bus_req, 0);
      check_output("bus_we", bus_we, 0);
      check_output("bus_addr", bus_addr, 0);
      check_output("bus_wdata", bus_wdata, 0);
      check_output("bus_be", bus_be, 0);
   endtask

   initial begin
      logic        r;
      logic        w;
      logic [31:0] ra;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [2:0]  dt;
      int          dl;
      int          sel;

      n_checks = 0;
      n_fail   = 0;
      last_data = '0;
      rst_n = 1'b0;
      r_mem_enable = 1'b0; w_mem_enable = 1'b0;
      r_mem_addr = '0; w_mem_addr = '0; w_mem_data = '0; data_type = '0;
      bus_ack = 1'b0; bus_rdata = '0;

      vectors.push_back(mk(1,0,32'h100,0,0,3'd3,0,32'hDEADBEEF, 1,0,1,32'hDEADBEEF,32'h100,4'hF,0));
      vectors.push_back(mk(1,0,32'h103,0,0,3'd1,0,32'h80FF0000, 1,0,1,32'hFFFFFF80,32'h100,4'hF,0));
      vectors.push_back(mk(1,0,32'h103,0,0,3'd4,0,32'h80FF0000, 1,0,1,32'h00000080,32'h100,4'hF,0));
      vectors.push_back(mk(0,1,0,32'h202,32'h1234ABCD,3'd2,0,0, 1,0,0,0,32'h200,4'hC,32'hABCDABCD));
      vectors.push_back(mk(1,0,32'h301,0,0,3'd3,0,32'h12345678, 0,1,1,0,0,4'hF,0));
      vectors.push_back(mk(1,0,32'h400,0,0,3'd3,4,32'h55555555, 4,1,1,0,32'h400,4'hF,0));
      vectors.push_back(mk(1,0,32'h404,0,0,3'd3,3,32'h11223344, 4,0,1,32'h11223344,32'h404,4'hF,0));
      vectors.push_back(mk(1,0,32'h106,0,0,3'd5,2,32'h80017FFF, 3,0,1,32'h00008001,32'h104,4'hF,0));
      vectors.push_back(mk(1,0,32'h106,0,0,3'd2,1,32'h80017FFF, 2,0,1,32'hFFFF8001,32'h104,4'hF,0));
      vectors.push_back(mk(0,1,0,32'h501,32'h000000A5,3'd1,0,0, 1,0,0,0,32'h500,4'h2,32'hA5A5A5A5));
      vectors.push_back(mk(1,1,32'h600,32'h604,32'hCAFEF00D,3'd3,0,32'h77777777, 1,1,0,0,32'h604,4'hF,32'hCAFEF00D));
      vectors.push_back(mk(0,1,0,32'h703,32'h00001111,3'd5,0,0, 0,1,0,0,0,4'hF,0));
      vectors.push_back(mk(0,1,0,32'h800,32'h01020304,3'd6,1,0, 2,0,0,0,32'h800,4'hF,32'h01020304));
      vectors.push_back(mk(1,0,32'h802,0,0,3'd7,0,32'h99999999, 0,1,1,0,0,4'hF,0));
      vectors.push_back(mk(0,1,0,32'h900,32'h0BADF00D,3'd3,9,0, 4,1,0,0,32'h900,4'hF,32'h0BADF00D));
      vectors.push_back(mk(1,0,32'h101,0,0,3'd4,0,32'h0000C300, 1,0,1,32'h000000C3,32'h100,4'hF,0));
      vectors.push_back(mk(1,0,32'h102,0,0,3'd1,0,32'h007F0000, 1,0,1,32'h0000007F,32'h100,4'hF,0));

      tag = "reset";
      repeat (2) @(posedge clk);
      #1;
      check_all_zero();
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_all_zero();

      for (int i = 0; i < vectors.size(); i++) begin
         tag = $sformatf("vec%0d", i);
         apply_stimulus(vectors[i]);
      end

      tag = "rst_busy";
      r_mem_enable = 1'b1;
      r_mem_addr   = 32'h00000100;
      data_type    = 3'd3;
      @(posedge clk); #1;
      check_output("bus_req_before", bus_req, 1);
      rst_n = 1'b0;
      #1;
      check_all_zero();
      r_mem_enable = 1'b0;
      last_data = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus_ack   = 1'b1;
      bus_rdata = 32'hA5A5A5A5;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      check_all_zero();
      @(posedge clk); #1;
      check_all_zero();

      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 7);
         r  = (sel == 0) || (sel < 4);
         w  = (sel == 0) || (sel >= 4);
         ra = $urandom;
         wa = $urandom;
         wd = $urandom;
         rd = $urandom;
         dt = 3'($urandom_range(1, 7));
         dl = $urandom_range(0, 5);
         tag = $sformatf("rnd%0d", i);
         apply_stimulus(model(r, w, ra, wa, wd, dt, dl, rd));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_bus_responder.md
RAM_BUS_RESPONDER -- requirements
Module: ram_bus_responder

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255: maximum BUSY cycles without bus_ack_i before an access aborts; legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port r_mem_enable_i, input, 1: load request from the EX/MEM-WB pipeline register.
REQ-005 SHALL have port r_mem_addr_i, input, 32: load byte address.
REQ-006 SHALL have port w_mem_enable_i, input, 1: store request.
REQ-007 SHALL have port w_mem_addr_i, input, 32: store byte address.
REQ-008 SHALL have port w_mem_data_i, input, 32: store data, right-aligned.
REQ-009 SHALL have port data_type_i, input, 3: access type; 0 none, 1 byte signed, 2 half signed, 3 word, 4 byte unsigned, 5 half unsigned; 6 and 7 behave as 3.
REQ-010 SHALL have port r_mem_data_o, output, 32: extended load result.
REQ-011 SHALL have port r_data_valid_o, output, 1: one-cycle pulse qualifying r_mem_data_o.
REQ-012 SHALL have port hold_req_o, output, 1: stall request to the hold controller; the controller maps it to a hold_wait.
REQ-013 SHALL have port mem_err_o, output, 1: one-cycle pulse flagging a misaligned, conflicting, or timed-out access.
REQ-014 SHALL have bus ports bus_req_o (out, 1), bus_we_o (out, 1), bus_addr_o (out, 32, bits [1:0] = 0), bus_wdata_o (out, 32), bus_be_o (out, 4), bus_ack_i (in, 1), bus_rdata_i (in, 32).

Function
REQ-015 SHALL implement states IDLE, BUSY and RESP, with 3-bit encoding or one-hot.
REQ-016 IDLE: a request (r or w enable) that is aligned and conflict-free SHALL latch the address, type, direction, byte enables and write data, then enter BUSY.
REQ-017 IDLE: a misaligned request SHALL enter RESP directly, with no bus transaction and the error flag set. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
REQ-018 IDLE: if r and w are both enabled, the store SHALL take priority and the error flag SHALL be set.
REQ-019 BUSY: bus_req_o SHALL be 1 and bus signals SHALL hold the latched values; on bus_ack_i=1, the state SHALL move to RESP, bus_rdata_i SHALL be captured, and bus_req_o SHALL be 0 from the next cycle.
REQ-020 BUSY: a timeout counter SHALL reset to 0 on entry and increment each cycle without ack; on reaching BUS_TIMEOUT it SHALL drop bus_req_o, set the error flag and enter RESP. An ack in the same cycle SHALL take precedence over the timeout.
REQ-021 RESP: the state SHALL last one cycle, then return to IDLE. Inputs SHALL be ignored in RESP, because the pipeline register still holds the completed request.
REQ-022 RESP: for a load, r_data_valid_o SHALL be 1; it SHALL also be 1 on an erroring load, with r_mem_data_o=0. mem_err_o SHALL be 1 if the error flag is set.
REQ-023 hold_req_o SHALL be combinational: 1 in IDLE with any enable, 1 in BUSY, 0 in RESP. Minimum access latency SHALL be 3 cycles (IDLE, BUSY with ack, RESP).
REQ-024 Store lanes: byte SHALL set be=1<<addr[1:0] and wdata={4{data[7:0]}}. Half SHALL set be=0011 or 1100 (by addr[1]) and wdata={2{data[15:0]}}. Word or none SHALL set be=1111 and wdata=data. For loads, be SHALL be 1111.
REQ-025 Load extraction: the selected byte or half from the captured word SHALL be sign-extended (types 1, 2) or zero-extended (4, 5); word SHALL pass unchanged.
REQ-026 r_mem_data_o SHALL hold its last value outside RESP. r_data_valid_o and mem_err_o SHALL be 0 outside RESP.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, clear the timeout counter and set every output to 0, including bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o and r_mem_data_o.
REQ-028 Reset during BUSY SHALL abandon the access; a late bus_ack_i after reset release SHALL be ignored in IDLE.

Verification
REQ-029 Word load: addr 0x100, type 3, ack on the 1st BUSY cycle with rdata 0xDEADBEEF -> bus_req 1 cycle; RESP r_data_valid_o=1, r_mem_data_o=0xDEADBEEF; hold_req_o 1 for 2 cycles.
REQ-030 Signed byte load: addr 0x103, type 1, rdata 0x80FF_0000 -> r_mem_data_o=0xFFFFFF80. With type 4 -> r_mem_data_o=0x00000080.
REQ-031 Half store: addr 0x202, data 0x1234ABCD, type 2 -> bus_be_o=1100, bus_wdata_o=0xABCDABCD, bus_addr_o=0x200, bus_we_o=1.
REQ-032 Misaligned word load at 0x301 -> no bus_req_o; next cycle mem_err_o=1, r_data_valid_o=1, r_mem_data_o=0.
REQ-033 Timeout: BUS_TIMEOUT=4, no ack -> bus_req_o high exactly 4 cycles, then mem_err_o pulse; ack 1 cycle earlier -> normal completion, no error.
REQ-034 Reset mid-BUSY, then ack asserted 1 cycle after release -> outputs 0, no r_data_valid_o, state IDLE.
